// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin share of one combinational ALU between the
// integer EX stage (requester 0) and the FP pipe (requester 1). Operands are
// registered for the whole (possibly multicycle) operation and the result is
// returned on a valid/ready response port tagged with the requester id.
module alu_share_arbiter #(
    parameter int DATA_W  = 64,
    parameter int FP_LAT  = 3,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              req0_valid,
    input  logic              req1_valid,
    output logic              req0_ready,
    output logic              req1_ready,
    input  logic [4:0]        req0_op,
    input  logic [4:0]        req1_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [4:0]        req0_shamt,
    input  logic [4:0]        req1_shamt,
    output logic [DATA_W-1:0] alu_op1,
    output logic [DATA_W-1:0] alu_op2,
    output logic [4:0]        alu_operation,
    output logic [4:0]        alu_shamt,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic              alu_overflow,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_id,
    output logic [DATA_W-1:0] resp_result,
    output logic              resp_zero,
    output logic              resp_overflow,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [4:0]        op_q, shamt_q;
    logic [DATA_W-1:0] a_q, b_q;
    logic              id_q;
    logic              last_q;
    logic [3:0]        cnt_q;
    logic [DATA_W-1:0] result_q;
    logic              zero_q, ovf_q;

    logic              grant0, grant1;
    logic              accept0, accept1, accept;
    logic [4:0]        sel_op, sel_shamt;
    logic [DATA_W-1:0] sel_a, sel_b;

    // Hold cycles per op; every op not listed (undefined codes too) takes one.
    function automatic logic [3:0] op_lat(input logic [4:0] op);
        case (op)
            5'h0C, 5'h0D: return 4'(FP_LAT);
            5'h0F:        return 4'(MUL_LAT);
            5'h10:        return 4'(DIV_LAT);
            default:      return 4'd1;
        endcase
    endfunction

    // Round-robin grant: a lone requester wins, on contention the one not served last wins.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
            grant0 = last_q;
            grant1 = !last_q;
        end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
        end
    end

    // Ready only in IDLE, never while flushing or while reset holds all outputs low.
    assign req0_ready = rst_n && (state_q == IDLE) && !flush && grant0;
    assign req1_ready = rst_n && (state_q == IDLE) && !flush && grant1;
    assign accept0    = req0_valid && req0_ready;
    assign accept1    = req1_valid && req1_ready;
    assign accept     = accept0 || accept1;

    assign sel_op    = accept1 ? req1_op    : req0_op;
    assign sel_a     = accept1 ? req1_a     : req0_a;
    assign sel_b     = accept1 ? req1_b     : req0_b;
    assign sel_shamt = accept1 ? req1_shamt : req0_shamt;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all registers update together.
            state_q <= state_d;
        end
    end

    // Next-state: flush beats both completion and a simultaneous resp_ready.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    if (flush) state_d = IDLE;
                     else if (cnt_q == 4'd0) state_d = DONE;
            DONE:    if (flush || resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand capture on accept, hold countdown in EXEC, result capture on the last EXEC edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: every register here is a real control/data flop, so all are reset; there is no memory array to exempt.
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            shamt_q  <= '0;
            id_q     <= 1'b0;
            last_q   <= 1'b1;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (accept) begin
            op_q    <= sel_op;
            a_q     <= sel_a;
            b_q     <= sel_b;
            shamt_q <= sel_shamt;
            id_q    <= accept1;
            last_q  <= accept1;
            cnt_q   <= op_lat(sel_op) - 4'd1;
        end else if (state_q == EXEC && !flush) begin
            if (cnt_q == 4'd0) begin
                result_q <= alu_result;
                zero_q   <= alu_zero;
                ovf_q    <= alu_overflow;
            end else begin
                cnt_q <= cnt_q - 4'd1;
            end
        end
    end

    // The ALU sees its no-op outside EXEC; operand registers keep their last values.
    assign alu_operation = (state_q == EXEC) ? op_q : 5'd0;
    assign alu_op1       = a_q;
    assign alu_op2       = b_q;
    assign alu_shamt     = shamt_q;

    assign resp_valid    = (state_q == DONE);
    assign resp_id       = id_q;
    assign resp_result   = result_q;
    assign resp_zero     = zero_q;
    assign resp_overflow = ovf_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model (accept time + latency deadline, pending response).
module tb_alu_share_arbiter;

    localparam int DW  = 64;
    localparam int FP  = 3;
    localparam int MUL = 4;
    localparam int DIV = 8;

    logic          clk, rst_n, flush;
    logic          req0_valid, req1_valid, req0_ready, req1_ready;
    logic [4:0]    req0_op, req1_op, req0_shamt, req1_shamt;
    logic [DW-1:0] req0_a, req1_a, req0_b, req1_b;
    logic [DW-1:0] alu_op1, alu_op2, alu_result;
    logic [4:0]    alu_operation, alu_shamt;
    logic          alu_zero, alu_overflow;
    logic          resp_valid, resp_ready, resp_id, resp_zero, resp_overflow, busy;
    logic [DW-1:0] resp_result;

    alu_share_arbiter #(.DATA_W(DW), .FP_LAT(FP), .MUL_LAT(MUL), .DIV_LAT(DIV)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_op(req0_op), .req1_op(req1_op),
        .req0_a(req0_a), .req1_a(req1_a), .req0_b(req0_b), .req1_b(req1_b),
        .req0_shamt(req0_shamt), .req1_shamt(req1_shamt),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_operation(alu_operation),
        .alu_shamt(alu_shamt), .alu_result(alu_result), .alu_zero(alu_zero),
        .alu_overflow(alu_overflow), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_result(resp_result), .resp_zero(resp_zero),
        .resp_overflow(resp_overflow), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in ALU: {overflow, zero, result}; op 0 and unknown codes give all zeros.
    function automatic logic [DW+1:0] alu_model(input logic [4:0] op, input logic [DW-1:0] a,
                                                input logic [DW-1:0] b, input logic [4:0] sh);
        logic [DW-1:0] r;
        logic known, ov;
        r = '0; known = 1'b1; ov = 1'b0;
        case (op)
            5'h02: r = a | b;
            5'h03: begin r = a + b; ov = (a[DW-1] == b[DW-1]) && (r[DW-1] != a[DW-1]); end
            5'h04: r = a - b;
            5'h05: r = a << sh;
            5'h0C, 5'h0D: r = a + b;
            5'h0F: r = a * b;
            5'h10: r = (b[31:0] == 32'd0) ? '0 : {a[31:0] % b[31:0], a[31:0] / b[31:0]};
            default: known = 1'b0;
        endcase
        return {ov, known && (r == '0), r};
    endfunction

    assign {alu_overflow, alu_zero, alu_result} = alu_model(alu_operation, alu_op1, alu_op2, alu_shamt);

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    // Transaction-level model.
    bit            m_active, m_rv, m_last, m_id;
    int            m_cyc, m_lat;
    logic [4:0]    m_op, m_sh;
    logic [DW-1:0] m_a, m_b, m_res;
    logic          m_z, m_o;
    bit            e0, e1;
    bit            p_rst, p_flush, p_v0, p_v1, p_r0, p_r1, p_rr;
    bit            acc0, acc1;

    function automatic int lat_of(input logic [4:0] op);
        if (op == 5'h0C || op == 5'h0D) return FP;
        if (op == 5'h0F) return MUL;
        if (op == 5'h10) return DIV;
        return 1;
    endfunction

    task automatic model_reset();
        m_active = 0; m_rv = 0; m_last = 1; m_id = 0; m_cyc = 0; m_lat = 0;
        m_op = '0; m_sh = '0; m_a = '0; m_b = '0; m_res = '0; m_z = 0; m_o = 0;
    endtask

    task automatic model_accept(input bit id);
        m_active = 1; m_cyc = 0; m_last = id; m_id = id;
        m_op = id ? req1_op    : req0_op;
        m_a  = id ? req1_a     : req0_a;
        m_b  = id ? req1_b     : req0_b;
        m_sh = id ? req1_shamt : req0_shamt;
        m_lat = lat_of(m_op);
    endtask

    task automatic compare();
        if (!rst_n) model_reset();
        e0 = 0; e1 = 0;
        if (rst_n && !m_active && !m_rv && !flush) begin
            if (req0_valid && req1_valid) begin
                e0 = (m_last == 1'b1);
                e1 = (m_last == 1'b0);
            end else begin
                e0 = req0_valid;
                e1 = req1_valid;
            end
        end
        check("req0_ready", req0_ready, e0);
        check("req1_ready", req1_ready, e1);
        check("busy", busy, m_active || m_rv);
        check("alu_operation", alu_operation, m_active ? m_op : 5'd0);
        check("alu_op1", alu_op1, m_a);
        check("alu_op2", alu_op2, m_b);
        check("alu_shamt", alu_shamt, m_sh);
        check("resp_valid", resp_valid, m_rv);
        check("resp_result", resp_result, m_res);
        check("resp_zero", resp_zero, m_z);
        check("resp_overflow", resp_overflow, m_o);
        if (m_rv) check("resp_id", resp_id, m_id);
    endtask

    task automatic model_edge();
        acc0 = 0; acc1 = 0;
        if (!p_rst) begin
            model_reset();
        end else if (m_rv) begin
            if (p_flush || p_rr) m_rv = 0;
        end else if (m_active) begin
            if (p_flush) m_active = 0;
            else begin
                m_cyc++;
                if (m_cyc == m_lat) begin
                    m_active = 0;
                    m_rv = 1;
                    {m_o, m_z, m_res} = alu_model(m_op, m_a, m_b, m_sh);
                end
            end
        end else if (p_v0 && p_r0) begin
            acc0 = 1; model_accept(1'b0);
        end else if (p_v1 && p_r1) begin
            acc1 = 1; model_accept(1'b1);
        end
    endtask

    // One clock: compare at the falling edge, advance the model just after the rising edge.
    task automatic cycle();
        @(negedge clk);
        compare();
        p_rst = rst_n; p_flush = flush; p_v0 = req0_valid; p_v1 = req1_valid;
        p_r0 = e0; p_r1 = e1; p_rr = resp_ready;
        @(posedge clk);
        #1;
        model_edge();
    endtask

    task automatic do_reset();
        rst_n = 0; flush = 0; resp_ready = 0; req0_valid = 0; req1_valid = 0;
        repeat (2) cycle();
        rst_n = 1;
    endtask

    task automatic set_req(input bit id, input logic [4:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        if (id) begin req1_valid = 1; req1_op = op; req1_a = a; req1_b = b; req1_shamt = 5'd0; end
        else    begin req0_valid = 1; req0_op = op; req0_a = a; req0_b = b; req0_shamt = 5'd0; end
    endtask

    logic [4:0]    op_tab [9] = '{5'h02, 5'h03, 5'h04, 5'h05, 5'h0C, 5'h0D, 5'h0F, 5'h10, 5'h1F};
    int            grants[$];
    logic [DW-1:0] results[$];
    int            ids[$];

    initial begin
        req0_op = '0; req1_op = '0; req0_a = '0; req1_a = '0; req0_b = '0; req1_b = '0;
        req0_shamt = '0; req1_shamt = '0;
        model_reset();
        do_reset();
        #1;
        check("reset busy", busy, 1'b0);
        check("reset resp_valid", resp_valid, 1'b0);

        // Single add from requester 0.
        resp_ready = 1; set_req(0, 5'h03, 64'd5, 64'd7);
        #1 check("t1 req0_ready", req0_ready, 1'b1);
        cycle(); req0_valid = 0;
        #1 check("t1 ready drop", req0_ready, 1'b0);
        check("t1 alu_operation", alu_operation, 5'h03);
        cycle();
        #1 check("t1 resp_valid", resp_valid, 1'b1);
        check("t1 resp_result", resp_result, 64'd12);
        check("t1 resp_id", resp_id, 1'b0);
        check("t1 resp_overflow", resp_overflow, 1'b0);
        cycle();
        #1 check("t1 resp drop", resp_valid, 1'b0);

        // Both requesters hammering: grants alternate starting with 0.
        do_reset();
        resp_ready = 1; set_req(0, 5'h02, 64'd1, 64'd2); set_req(1, 5'h02, 64'd4, 64'd8);
        for (int k = 0; k < 20; k++) begin
            #1;
            if (req0_ready) grants.push_back(0);
            if (req1_ready) grants.push_back(1);
            if (resp_valid) begin results.push_back(resp_result); ids.push_back(int'(resp_id)); end
            cycle();
        end
        check("t2 grant count", (grants.size() >= 4) ? 64'd1 : 64'd0, 64'd1);
        check("t2 resp count", (results.size() >= 4) ? 64'd1 : 64'd0, 64'd1);
        if (grants.size() >= 4 && results.size() >= 4) begin
            for (int k = 0; k < 4; k++) begin
                check("t2 grant", grants[k], (k % 2 == 0) ? 64'd0 : 64'd1);
                check("t2 result", results[k], (k % 2 == 0) ? 64'd3 : 64'd12);
                check("t2 id", ids[k], (k % 2 == 0) ? 64'd0 : 64'd1);
            end
        end

        // Multiply from requester 1 holds the ALU for MUL cycles.
        do_reset();
        resp_ready = 1; set_req(1, 5'h0F, 64'd6, 64'd7);
        #1 check("t3 req1_ready", req1_ready, 1'b1);
        cycle(); req1_valid = 0;
        for (int k = 0; k < MUL; k++) begin
            #1 check("t3 alu_operation", alu_operation, 5'h0F);
            check("t3 alu_op1", alu_op1, 64'd6);
            check("t3 alu_op2", alu_op2, 64'd7);
            check("t3 early resp", resp_valid, 1'b0);
            cycle();
        end
        #1 check("t3 resp_valid", resp_valid, 1'b1);
        check("t3 resp_result", resp_result, 64'd42);
        check("t3 resp_id", resp_id, 1'b1);
        cycle();

        // Divide with requester 1 waiting, then 3 cycles of backpressure.
        do_reset();
        set_req(0, 5'h10, 64'd17, 64'd5); set_req(1, 5'h02, 64'd1, 64'd1);
        #1 check("t4 req0_ready", req0_ready, 1'b1);
        check("t4 req1 blocked", req1_ready, 1'b0);
        cycle(); req0_valid = 0;
        for (int k = 0; k < DIV; k++) begin
            #1 check("t4 req1 wait", req1_ready, 1'b0);
            check("t4 early resp", resp_valid, 1'b0);
            cycle();
        end
        for (int k = 0; k < 3; k++) begin
            #1 check("t4 stall valid", resp_valid, 1'b1);
            check("t4 stall result", resp_result, 64'h0000_0002_0000_0003);
            check("t4 stall busy", busy, 1'b1);
            check("t4 stall req1", req1_ready, 1'b0);
            cycle();
        end
        resp_ready = 1;
        cycle();
        #1 check("t4 consumed", resp_valid, 1'b0);
        check("t4 req1 granted", req1_ready, 1'b1);
        cycle(); req1_valid = 0;
        repeat (3) cycle();

        // Flush during the second EXEC cycle of a divide.
        do_reset();
        resp_ready = 1; set_req(0, 5'h10, 64'd100, 64'd7);
        cycle(); req0_valid = 0;
        cycle();
        flush = 1;
        cycle();
        flush = 0;
        #1 check("t5 idle after flush", busy, 1'b0);
        check("t5 no resp", resp_valid, 1'b0);
        set_req(0, 5'h03, 64'd1, 64'd1);
        #1 check("t5 next accepted", req0_ready, 1'b1);
        cycle(); req0_valid = 0;
        repeat (DIV + 2) begin
            #1 check("t5 no stale resp", (resp_valid && resp_result != 64'd2) ? 64'd1 : 64'd0, 64'd0);
            cycle();
        end

        // Reset in the middle of an FP add with requester 0 served last.
        do_reset();
        resp_ready = 1; set_req(0, 5'h0C, 64'd9, 64'd9);
        cycle(); req0_valid = 0;
        cycle();
        rst_n = 0; set_req(1, 5'h02, 64'd3, 64'd3);
        #1 check("t6 rst busy", busy, 1'b0);
        check("t6 rst alu_operation", alu_operation, 5'd0);
        check("t6 rst alu_op1", alu_op1, 64'd0);
        check("t6 rst req1_ready", req1_ready, 1'b0);
        check("t6 rst resp_valid", resp_valid, 1'b0);
        cycle();
        rst_n = 1; set_req(0, 5'h03, 64'd2, 64'd2);
        #1 check("t6 req0 first", req0_ready, 1'b1);
        check("t6 req1 waits", req1_ready, 1'b0);
        cycle(); req0_valid = 0; req1_valid = 0;
        repeat (4) cycle();

        // Randomized traffic, flush and backpressure.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            if (acc0) req0_valid = 0;
            if (acc1) req1_valid = 0;
            if (!req0_valid && $urandom_range(0, 2) == 0) begin
                set_req(0, op_tab[$urandom_range(0, 8)], {$urandom, $urandom}, {$urandom, $urandom});
                req0_shamt = 5'($urandom_range(0, 31));
            end
            if (!req1_valid && $urandom_range(0, 2) == 0) begin
                set_req(1, op_tab[$urandom_range(0, 8)], {$urandom, $urandom}, {32'd0, 32'($urandom_range(0, 40))});
                req1_shamt = 5'($urandom_range(0, 31));
            end
            flush      = ($urandom_range(0, 15) == 0);
            resp_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        flush = 0; req0_valid = 0; req1_valid = 0; resp_ready = 1;
        repeat (12) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
